// File: rtl/regfile_wb_pkg.sv
// Shared codes for the register-file write-back controller: op classes, mux
// selector encodings, FSM states and the first-write selector lookup.
package regfile_wb_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_RTYPE = 3'd1,
    OP_IALU  = 3'd2,
    OP_LOAD  = 3'd3,
    OP_JAL   = 3'd4,
    OP_PUSH  = 3'd5,
    OP_POP   = 3'd6,
    OP_RSVD  = 3'd7
  } wb_op_e;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_SP = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;
  localparam logic [1:0] RD_RD = 2'b11;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_MEM = 3'd1,
    S_WRITE1   = 3'd2,
    S_WRITE2   = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  // {reg_dst, mem_to_reg} for the first (or only) write of each class
  function automatic logic [3:0] write1_sel(input wb_op_e op);
    case (op)
      OP_RTYPE: write1_sel = {RD_RD, M2R_ALU};
      OP_IALU:  write1_sel = {RD_RT, M2R_ALU};
      OP_LOAD:  write1_sel = {RD_RT, M2R_MDR};
      OP_JAL:   write1_sel = {RD_RA, M2R_PC};
      OP_PUSH:  write1_sel = {RD_SP, M2R_ALU};
      OP_POP:   write1_sel = {RD_RT, M2R_MDR};
      default:  write1_sel = {RD_RT, M2R_ALU};
    endcase
  endfunction

endpackage

// File: rtl/wb_wait_counter.sv
// 8-bit clear/enable counter bounding the memory wait; tc_o flags the last
// permitted wait cycle (count == MEM_TIMEOUT-1).
module wb_wait_counter #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: sequences one or two register-file writes per decoded
// op, waiting on memory for loads/pops. Outputs are registered from next state.
module regfile_wb_ctrl
  import regfile_wb_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] wb_op,
  input  logic       mem_ready,
  input  logic       flush,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       overrun
);

  state_e     state_q, state_d;
  wb_op_e     op_q, op_d;
  logic [1:0] reg_dst_q, reg_dst_d;
  logic [1:0] m2r_q, m2r_d;
  logic       reg_write_q, reg_write_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       timeout_q, timeout_d;
  logic       overrun_q, overrun_d;
  logic       cnt_clr, cnt_en, cnt_tc;

  wb_wait_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    timeout_d   = 1'b0;
    reg_dst_d   = RD_RT;
    m2r_d       = M2R_ALU;
    reg_write_d = 1'b0;
    // A start in DONE still counts as busy; only IDLE accepts work
    overrun_d   = overrun_q | (start & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = wb_op_e'(wb_op);
          case (wb_op_e'(wb_op))
            OP_RTYPE, OP_IALU, OP_JAL, OP_PUSH: state_d = S_WRITE1;
            OP_LOAD, OP_POP: begin
              state_d = S_WAIT_MEM;
              cnt_clr = 1'b1;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_WAIT_MEM: begin
        if (mem_ready) begin
          state_d = S_WRITE1;
        end else if (cnt_tc) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_WRITE1: state_d = (op_q == OP_POP) ? S_WRITE2 : S_DONE;
      S_WRITE2: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Flush drops the next state; a write already registered finishes this cycle
    if (flush) begin
      state_d   = S_IDLE;
      op_d      = op_q;
      timeout_d = 1'b0;
    end

    if (state_d == S_WRITE1) begin
      {reg_dst_d, m2r_d} = write1_sel(op_d);
      reg_write_d        = 1'b1;
    end else if (state_d == S_WRITE2) begin
      reg_dst_d   = RD_SP;
      m2r_d       = M2R_ALU;
      reg_write_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NONE;
      reg_dst_q   <= RD_RT;
      m2r_q       <= M2R_ALU;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      reg_dst_q   <= reg_dst_d;
      m2r_q       <= m2r_d;
      reg_write_q <= reg_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign reg_dst    = reg_dst_q;
  assign mem_to_reg = m2r_q;
  assign reg_write  = reg_write_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed table-driven bench for regfile_wb_ctrl, plus a hand sequence for
// asynchronous reset in the middle of a POP.
module tb_regfile_wb_ctrl;

  localparam int unsigned MT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] wb_op;
  logic       mem_ready;
  logic       flush;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       overrun;

  regfile_wb_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .wb_op      (wb_op),
    .mem_ready  (mem_ready),
    .flush      (flush),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // exp = {reg_dst, mem_to_reg, reg_write, busy, done, timeout, overrun}
  typedef struct {
    logic       s;
    logic [2:0] op;
    logic       mr;
    logic       fl;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [8:0] E_IDLE  = 9'b00_00_0_0_0_0_0;
  localparam logic [8:0] E_WAIT  = 9'b00_00_0_1_0_0_0;
  localparam logic [8:0] E_DONE  = 9'b00_00_0_1_1_0_0;
  localparam logic [8:0] E_DTO   = 9'b00_00_0_1_1_1_0;
  localparam logic [8:0] E_RTYPE = 9'b11_00_1_1_0_0_0;
  localparam logic [8:0] E_IALU  = 9'b00_00_1_1_0_0_0;
  localparam logic [8:0] E_MDR   = 9'b00_01_1_1_0_0_0;
  localparam logic [8:0] E_JAL   = 9'b10_10_1_1_0_0_0;
  localparam logic [8:0] E_SP    = 9'b01_00_1_1_0_0_0;
  localparam logic [8:0] OV      = 9'b00_00_0_0_0_0_1;

  function automatic logic [8:0] obs();
    return {reg_dst, mem_to_reg, reg_write, busy, done, timeout, overrun};
  endfunction

  task automatic add(input logic s, input logic [2:0] op, input logic mr,
                     input logic fl, input logic [8:0] exp);
    vec_t v;
    v.s = s; v.op = op; v.mr = mr; v.fl = fl; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rd,m2r,rw,busy,done,to,ovr}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; wb_op = 3'd0; mem_ready = 1'b0; flush = 1'b0;

    // inputs of each row are applied for one cycle; exp is seen the cycle after
    add(1, 3'd1, 0, 0, E_RTYPE);          // RTYPE
    add(0, 3'd0, 0, 0, E_DONE);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd2, 0, 0, E_IALU);           // IALU
    add(0, 3'd0, 0, 0, E_DONE);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd4, 0, 0, E_JAL);            // JAL back-to-back after done
    add(0, 3'd0, 0, 0, E_DONE);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd3, 0, 0, E_WAIT);           // LOAD, mem_ready 3 cycles later
    add(0, 3'd0, 0, 0, E_WAIT);
    add(0, 3'd0, 0, 0, E_WAIT);
    add(0, 3'd0, 1, 0, E_MDR);
    add(0, 3'd0, 0, 0, E_DONE);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd6, 0, 0, E_WAIT);           // POP, mem_ready immediate
    add(0, 3'd0, 1, 0, E_MDR);
    add(0, 3'd0, 0, 0, E_SP);
    add(0, 3'd0, 0, 0, E_DONE);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd3, 0, 0, E_WAIT);           // LOAD timeout, MT=4
    add(0, 3'd0, 0, 0, E_WAIT);
    add(0, 3'd0, 0, 0, E_WAIT);
    add(0, 3'd0, 0, 0, E_WAIT);
    add(0, 3'd0, 0, 0, E_DTO);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd3, 0, 0, E_WAIT);           // LOAD, mem_ready on the last wait cycle
    add(0, 3'd0, 0, 0, E_WAIT);
    add(0, 3'd0, 0, 0, E_WAIT);
    add(0, 3'd0, 0, 0, E_WAIT);
    add(0, 3'd0, 1, 0, E_MDR);
    add(0, 3'd0, 0, 0, E_DONE);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd0, 0, 0, E_DONE);           // NONE
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd7, 0, 0, E_DONE);           // reserved
    add(0, 3'd0, 1, 0, E_IDLE);
    add(0, 3'd0, 1, 0, E_IDLE);           // stray mem_ready in IDLE
    add(1, 3'd5, 0, 0, E_SP);             // PUSH
    add(0, 3'd0, 0, 0, E_DONE);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd1, 0, 0, E_RTYPE);          // flush in WRITE1
    add(0, 3'd0, 0, 1, E_IDLE);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd6, 0, 0, E_WAIT);           // POP flushed after first write
    add(0, 3'd0, 1, 0, E_MDR);
    add(0, 3'd0, 0, 1, E_IDLE);
    add(0, 3'd0, 0, 0, E_IDLE);
    add(1, 3'd4, 0, 0, E_JAL);            // JAL, then start while busy
    add(1, 3'd1, 0, 0, E_DONE | OV);
    add(1, 3'd1, 0, 0, E_IDLE | OV);      // start in DONE cycle ignored
    add(0, 3'd0, 0, 0, E_IDLE | OV);
    add(1, 3'd3, 0, 0, E_WAIT | OV);      // LOAD flushed in WAIT_MEM
    add(0, 3'd0, 1, 1, E_IDLE | OV);
    add(0, 3'd0, 0, 0, E_IDLE | OV);
    add(0, 3'd0, 0, 0, E_IDLE | OV);

    #12;
    check("reset_state", obs(), E_IDLE);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_reset_idle", obs(), E_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].s; wb_op = vecs[i].op; mem_ready = vecs[i].mr; flush = vecs[i].fl;
      tick();
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    start = 1'b0; mem_ready = 1'b0; flush = 1'b0;

    // async reset during the first POP write
    start = 1'b1; wb_op = 3'd6;
    tick();
    start = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("pop_write1_pre_reset", obs(), E_MDR | OV);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_immediate", obs(), E_IDLE);
    tick();
    check("reset_held", obs(), E_IDLE);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("after_reset_%0d", k), obs(), E_IDLE);
    end
    start = 1'b1; wb_op = 3'd1;
    tick();
    start = 1'b0;
    check("rtype_after_reset", obs(), E_RTYPE);
    tick();
    check("rtype_after_reset_done", obs(), E_DONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
